dcache_controller: RTL and testbench
====================================

Name: dcache_controller

Overview:
- MEM-stage L1 data cache controller.
- Consumes the EX/MEM register outputs: ALU result as address, store data, and the MemRead/MemWrite controls.
- Returns load data to the MEM/WB path and drives the pipeline-wide stall.
- Direct-mapped, write-back, write-allocate cache. Tag and data arrays are held internally. Misses are serviced over a 256-bit line interface to off-chip data memory.

Parameters:
- ADDR_W, 32: CPU byte-address width.
- SETS, 16: number of cache lines. Power of two; index width IDX_W = log2(SETS) = 4.
- LINE_W, 256: line width in bits (32 bytes, 8 words). Offset width 5, tag width TAG_W = ADDR_W-IDX_W-5 = 23.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- cpu_addr_i  in  32  byte address (ALU result from EX/MEM).
- cpu_data_i  in  32  store data.
- cpu_MemRead_i  in  1  load request.
- cpu_MemWrite_i  in  1  store request.
- cpu_data_o  out  32  load data.
- cpu_stall_o  out  1  stall to all pipeline registers.
- mem_data_i  in  256  refill line from memory.
- mem_ack_i  in  1  one-cycle completion pulse from memory.
- mem_addr_o  out  32  line address, low 5 bits always 0.
- mem_data_o  out  256  write-back line.
- mem_enable_o  out  1  memory request valid.
- mem_write_o  out  1  1 = write-back, 0 = refill.
- hit_cnt_o  out  32  optional statistics.
- miss_cnt_o  out  32  optional statistics.

Behaviour:
- Address split:
  - tag = addr[31:9]
  - index = addr[8:5]
  - word = addr[4:2]
  - addr[1:0] ignored; only word accesses are supported.
- Per-line state: valid, dirty, tag[22:0], data[255:0].
- Reset (rst_i sampled high at a posedge):
  - All valid/dirty bits cleared; state=IDLE.
  - mem_enable_o=0, mem_write_o=0, mem_addr_o=0, mem_data_o=0; counters=0.
  - Reset mid-miss abandons the transaction; no further enable is driven, and a late mem_ack_i is ignored in IDLE.
- Request: req = cpu_MemRead_i | cpu_MemWrite_i. If both are high, the access is treated as a store.
- hit = req & valid[index] & (tag match), evaluated combinationally only in IDLE.
- cpu_stall_o = req & ~hit, combinational. It is therefore high in the miss-detect cycle and in every miss-service cycle, and low on the final hit cycle.
- cpu_data_o:
  - Read hit: the selected word of the line, combinational, zero added latency.
  - Otherwise: 0.
- Store hit: at the posedge, the word at index/word is updated and dirty[index] is set.
- FSM states: IDLE, WRITEBACK, REFILL, REFILL_DONE.
  - IDLE:
    - req & ~hit & dirty → WRITEBACK.
    - req & ~hit & ~dirty → REFILL.
    - Otherwise stay.
  - WRITEBACK:
    - Drives mem_enable_o=1, mem_write_o=1, mem_addr_o={stored tag, index, 5'b0}, mem_data_o=stored line.
    - Held until mem_ack_i=1, then → REFILL.
  - REFILL:
    - Drives mem_enable_o=1, mem_write_o=0, mem_addr_o={cpu tag, index, 5'b0}.
    - On mem_ack_i: writes mem_data_i into the line, sets valid=1, dirty=0, tag=cpu tag; → REFILL_DONE.
  - REFILL_DONE:
    - mem_enable_o=0; → IDLE.
    - The next IDLE cycle re-evaluates and hits; a store then merges and sets dirty.
- mem_enable_o is deasserted in the cycle after the ack is sampled. It is never asserted in IDLE or REFILL_DONE.
- Miss latency, clean: 1 (detect) + refill wait (N cycles to ack) + 1 (REFILL_DONE) + hit cycle.
- Miss latency, dirty: additionally adds the write-back wait.
- Inputs are held stable by the stalled EX/MEM register throughout a miss; the controller does not re-latch them.
- mem_ack_i outside WRITEBACK/REFILL is ignored.

Optional Feature:
- Macro: DCACHE_STATS_EN.
- Defined:
  - hit_cnt_o increments on each IDLE hit cycle, excluding the first IDLE cycle after REFILL_DONE.
  - miss_cnt_o increments on each IDLE→WRITEBACK/REFILL transition.
  - Both counters are 32-bit and saturate at 0xFFFFFFFF.
  - Both clear on rst_i.
- Not defined: both outputs are constant 0 and no counter flops are present.

Test Plan:
- Reset then load 0x0000_0040 with memory returning a line whose word0 = 0x1234_5678, ack after 5 cycles:
  - stall high 7 cycles (1 detect + 5 REFILL cycles + 1 REFILL_DONE), then cpu_data_o=0x1234_5678 with stall low.
  - mem_addr_o=0x40, mem_write_o=0.
- Store 0xDEAD_BEEF to 0x44 after the previous refill: no stall; a subsequent load of 0x44 returns 0xDEAD_BEEF in the same cycle.
- Load 0x0000_0240 (same index 2, different tag) after the dirty store:
  - WRITEBACK to addr 0x40 with mem_data_o word1=0xDEAD_BEEF.
  - Then REFILL at 0x240; stall released only after REFILL_DONE.
- Assert rst_i during REFILL while mem_enable_o=1:
  - next cycle mem_enable_o=0 and state IDLE.
  - a load to 0x40 misses again (line invalidated).
  - a stray ack pulse has no effect.
- Both MemRead and MemWrite high on a hit to 0x48 with data 0x5: treated as a store, and the line is dirty afterwards.
- With DCACHE_STATS_EN, run the first three scenarios: hit_cnt_o=2 (the store hit and the immediate load hit), miss_cnt_o=2.

Source files
------------

// File: rtl/dcache_controller.sv
// ============================================================================
// dcache_controller -- MEM-stage L1 data cache controller.
//
// Direct-mapped, write-back, write-allocate data cache. Tag, valid, dirty and
// data arrays are held internally. A miss stalls the whole pipeline and is
// serviced over a full-line interface to off-chip memory: first an optional
// write-back of the dirty victim, then a refill of the requested line.
//
// Optional statistics counters are built only when DCACHE_STATS_EN is
// defined. Otherwise hit_cnt_o / miss_cnt_o are tied to zero and no counter
// flops exist.
//
// Ports
//   clk_i           clock, all state changes on the rising edge
//   rst_i           synchronous active-high reset
//   cpu_addr_i      byte address from EX/MEM (ALU result)
//   cpu_data_i      store data
//   cpu_MemRead_i   load request
//   cpu_MemWrite_i  store request (wins over a load if both are set)
//   cpu_data_o      load data, valid on a read hit, else 0
//   cpu_stall_o     pipeline stall, high while a request has not hit
//   mem_data_i      refill line from memory
//   mem_ack_i       one-cycle completion pulse from memory
//   mem_addr_o      line address (low offset bits zero)
//   mem_data_o      write-back line
//   mem_enable_o    memory request valid
//   mem_write_o     1 = write-back, 0 = refill
//   hit_cnt_o       hit counter (statistics build only)
//   miss_cnt_o      miss counter (statistics build only)
// ============================================================================
module dcache_controller #(
    parameter int ADDR_W = 32,
    parameter int SETS   = 16,
    parameter int LINE_W = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [31:0]       cpu_data_i,
    input  logic              cpu_MemRead_i,
    input  logic              cpu_MemWrite_i,
    output logic [31:0]       cpu_data_o,
    output logic              cpu_stall_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [31:0]       hit_cnt_o,
    output logic [31:0]       miss_cnt_o
);

    localparam int IDX_W  = $clog2(SETS);
    localparam int OFF_W  = $clog2(LINE_W / 8);
    localparam int WSEL_W = $clog2(LINE_W / 32);
    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        REFILL,
        REFILL_DONE
    } state_t;

    state_t state, nextState;

    // Per-line storage
    logic [SETS-1:0]   validArr;
    logic [SETS-1:0]   dirtyArr;
    logic [TAG_W-1:0]  tagArr  [SETS];
    logic [LINE_W-1:0] dataArr [SETS];

    // Address split
    logic [TAG_W-1:0]  cpuTag;
    logic [IDX_W-1:0]  idx;
    logic [WSEL_W-1:0] wsel;
    logic [1:0]        unusedByteBits;

    assign cpuTag         = cpu_addr_i[ADDR_W-1 -: TAG_W];
    assign idx            = cpu_addr_i[OFF_W +: IDX_W];
    assign wsel           = cpu_addr_i[2 +: WSEL_W];
    assign unusedByteBits = cpu_addr_i[1:0];   // word accesses only

    logic              req;
    logic              isStore;
    logic              hit;
    logic [LINE_W-1:0] lineSel;

    assign req     = cpu_MemRead_i | cpu_MemWrite_i;
    assign isStore = cpu_MemWrite_i;
    assign lineSel = dataArr[idx];

    // Hit is only meaningful in IDLE; during miss service the array is being
    // rewritten and the pipeline must stay stalled until REFILL_DONE passes.
    assign hit = req && (state == IDLE) && validArr[idx] && (tagArr[idx] == cpuTag);

    assign cpu_stall_o = req & ~hit;
    assign cpu_data_o  = (hit && !isStore) ? lineSel[{wsel, 5'b0} +: 32] : 32'd0;

    // ------------------------------------------------------------------
    // FSM: next state and memory-side outputs
    // ------------------------------------------------------------------
    always_comb begin
        nextState    = state;
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_data_o   = '0;
        unique case (state)
            IDLE: begin
                if (req && !hit)
                    nextState = (validArr[idx] && dirtyArr[idx]) ? WRITEBACK : REFILL;
            end
            WRITEBACK: begin
                mem_enable_o = 1'b1;
                mem_write_o  = 1'b1;
                mem_addr_o   = {tagArr[idx], idx, {OFF_W{1'b0}}};
                mem_data_o   = lineSel;
                if (mem_ack_i)
                    nextState = REFILL;
            end
            REFILL: begin
                mem_enable_o = 1'b1;
                mem_addr_o   = {cpuTag, idx, {OFF_W{1'b0}}};
                if (mem_ack_i)
                    nextState = REFILL_DONE;
            end
            REFILL_DONE: begin
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    logic refillWr;
    logic storeWr;

    assign refillWr = (state == REFILL) && mem_ack_i;
    assign storeWr  = hit && isStore;

    // ------------------------------------------------------------------
    // State register and line status bits
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            validArr <= '0;
            dirtyArr <= '0;
        end else begin
            state <= nextState;
            if (refillWr) begin
                validArr[idx] <= 1'b1;
                dirtyArr[idx] <= 1'b0;
            end else if (storeWr) begin
                dirtyArr[idx] <= 1'b1;
            end
        end
    end

    // Tag and data arrays carry no reset; validity is tracked in validArr.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (refillWr) begin
                dataArr[idx] <= mem_data_i;
                tagArr[idx]  <= cpuTag;
            end else if (storeWr) begin
                dataArr[idx][{wsel, 5'b0} +: 32] <= cpu_data_i;
            end
        end
    end

    // ------------------------------------------------------------------
    // Optional statistics
    // ------------------------------------------------------------------
`ifdef DCACHE_STATS_EN
    logic [31:0] hitCnt;
    logic [31:0] missCnt;
    logic        postRefill;   // first IDLE cycle after a refill: not a real hit

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hitCnt     <= '0;
            missCnt    <= '0;
            postRefill <= 1'b0;
        end else begin
            postRefill <= (state == REFILL_DONE);
            if (hit && !postRefill && (hitCnt != 32'hFFFF_FFFF))
                hitCnt <= hitCnt + 32'd1;
            if ((state == IDLE) && req && !hit && (missCnt != 32'hFFFF_FFFF))
                missCnt <= missCnt + 32'd1;
        end
    end

    assign hit_cnt_o  = hitCnt;
    assign miss_cnt_o = missCnt;
`else
    assign hit_cnt_o  = 32'd0;
    assign miss_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// ============================================================================
// tb_dcache_controller -- directed self-checking bench for dcache_controller.
//
// Inputs change 1 ns after a rising edge; outputs are sampled on the falling
// edge. Memory responses (ack + line) are driven directly by the sequence.
// ============================================================================
module tb_dcache_controller;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic [31:0]  cpu_addr_i;
    logic [31:0]  cpu_data_i;
    logic         cpu_MemRead_i;
    logic         cpu_MemWrite_i;
    logic [31:0]  cpu_data_o;
    logic         cpu_stall_o;
    logic [255:0] mem_data_i;
    logic         mem_ack_i;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic         mem_enable_o;
    logic         mem_write_o;
    logic [31:0]  hit_cnt_o;
    logic [31:0]  miss_cnt_o;

    dcache_controller dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .cpu_addr_i     (cpu_addr_i),
        .cpu_data_i     (cpu_data_i),
        .cpu_MemRead_i  (cpu_MemRead_i),
        .cpu_MemWrite_i (cpu_MemWrite_i),
        .cpu_data_o     (cpu_data_o),
        .cpu_stall_o    (cpu_stall_o),
        .mem_data_i     (mem_data_i),
        .mem_ack_i      (mem_ack_i),
        .mem_addr_o     (mem_addr_o),
        .mem_data_o     (mem_data_o),
        .mem_enable_o   (mem_enable_o),
        .mem_write_o    (mem_write_o),
        .hit_cnt_o      (hit_cnt_o),
        .miss_cnt_o     (miss_cnt_o)
    );

    always #5 clk_i = ~clk_i;

`ifdef DCACHE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    int tests = 0;
    int fails = 0;
    int stallCyc;

    logic [255:0] line1, line2, line3;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chkIdleMem(input string tag);
        chk({tag, " en"},   256'(mem_enable_o), 256'(0));
        chk({tag, " wr"},   256'(mem_write_o),  256'(0));
    endtask

    initial begin
        line1 = '0;
        line1[31:0]   = 32'h1234_5678;
        line1[63:32]  = 32'hA1A1_A1A1;
        line1[95:64]  = 32'hA2A2_A2A2;
        line2 = '0;
        line2[31:0]   = 32'hCAFE_F00D;
        line2[95:64]  = 32'h0000_0077;
        line3 = '0;
        line3[31:0]   = 32'h3333_3333;
        line3[95:64]  = 32'h4444_4444;

        rst_i          = 1'b1;
        cpu_addr_i     = '0;
        cpu_data_i     = '0;
        cpu_MemRead_i  = 1'b0;
        cpu_MemWrite_i = 1'b0;
        mem_data_i     = '0;
        mem_ack_i      = 1'b0;
        step();
        step();
        rst_i = 1'b0;

        // ---- reset state
        @(negedge clk_i);
        chkIdleMem("rst");
        chk("rst addr",  256'(mem_addr_o),  256'(0));
        chk("rst mdata", mem_data_o,        256'(0));
        chk("rst stall", 256'(cpu_stall_o), 256'(0));
        chk("rst data",  256'(cpu_data_o),  256'(0));
        chk("rst hits",  256'(hit_cnt_o),   256'(0));
        chk("rst miss",  256'(miss_cnt_o),  256'(0));

        // ---- S1: clean load miss at 0x40, ack on 5th refill cycle
        step();
        cpu_MemRead_i = 1'b1;
        cpu_addr_i    = 32'h0000_0040;
        stallCyc      = 0;
        @(negedge clk_i);
        stallCyc += int'(cpu_stall_o);
        chk("s1 detect stall", 256'(cpu_stall_o), 256'(1));
        chk("s1 detect en",    256'(mem_enable_o), 256'(0));
        for (int i = 0; i < 5; i++) begin
            step();
            mem_ack_i  = (i == 4);
            mem_data_i = line1;
            @(negedge clk_i);
            stallCyc += int'(cpu_stall_o);
            chk("s1 refill en",   256'(mem_enable_o), 256'(1));
            chk("s1 refill wr",   256'(mem_write_o),  256'(0));
            chk("s1 refill addr", 256'(mem_addr_o),   256'(32'h40));
        end
        step();
        mem_ack_i = 1'b0;
        @(negedge clk_i);
        stallCyc += int'(cpu_stall_o);
        chk("s1 done en", 256'(mem_enable_o), 256'(0));
        step();
        @(negedge clk_i);
        chk("s1 hit stall", 256'(cpu_stall_o), 256'(0));
        chk("s1 hit data",  256'(cpu_data_o),  256'(32'h1234_5678));
        chk("s1 stall cycles", 256'(stallCyc), 256'(7));

        // ---- S2: store hit to 0x44, then load it back
        step();
        cpu_MemRead_i  = 1'b0;
        cpu_MemWrite_i = 1'b1;
        cpu_addr_i     = 32'h0000_0044;
        cpu_data_i     = 32'hDEAD_BEEF;
        @(negedge clk_i);
        chk("s2 store stall", 256'(cpu_stall_o), 256'(0));
        chkIdleMem("s2 store");
        step();
        cpu_MemWrite_i = 1'b0;
        cpu_MemRead_i  = 1'b1;
        @(negedge clk_i);
        chk("s2 load stall", 256'(cpu_stall_o), 256'(0));
        chk("s2 load data",  256'(cpu_data_o),  256'(32'hDEAD_BEEF));

        // ---- S3: conflicting load 0x240 -> write-back of dirty 0x40 line
        step();
        cpu_addr_i = 32'h0000_0240;
        @(negedge clk_i);
        chk("s3 detect stall", 256'(cpu_stall_o), 256'(1));
        chk("s3 detect en",    256'(mem_enable_o), 256'(0));
        for (int i = 0; i < 3; i++) begin
            step();
            mem_ack_i = (i == 2);
            @(negedge clk_i);
            chk("s3 wb en",    256'(mem_enable_o), 256'(1));
            chk("s3 wb wr",    256'(mem_write_o),  256'(1));
            chk("s3 wb addr",  256'(mem_addr_o),   256'(32'h40));
            chk("s3 wb word1", 256'(mem_data_o[63:32]), 256'(32'hDEAD_BEEF));
            chk("s3 wb word0", 256'(mem_data_o[31:0]),  256'(32'h1234_5678));
            chk("s3 wb stall", 256'(cpu_stall_o), 256'(1));
        end
        for (int i = 0; i < 2; i++) begin
            step();
            mem_ack_i  = (i == 1);
            mem_data_i = line2;
            @(negedge clk_i);
            chk("s3 refill en",   256'(mem_enable_o), 256'(1));
            chk("s3 refill wr",   256'(mem_write_o),  256'(0));
            chk("s3 refill addr", 256'(mem_addr_o),   256'(32'h240));
            chk("s3 refill stall", 256'(cpu_stall_o), 256'(1));
        end
        step();
        mem_ack_i = 1'b0;
        @(negedge clk_i);
        chk("s3 done stall", 256'(cpu_stall_o), 256'(1));
        chk("s3 done en",    256'(mem_enable_o), 256'(0));
        step();
        @(negedge clk_i);
        chk("s3 hit stall", 256'(cpu_stall_o), 256'(0));
        chk("s3 hit data",  256'(cpu_data_o),  256'(32'hCAFE_F00D));
        chk("s3 hit count",  256'(hit_cnt_o),  256'(STATS ? 2 : 0));
        chk("s3 miss count", 256'(miss_cnt_o), 256'(STATS ? 2 : 0));

        // ---- S4: reset while a refill is outstanding
        step();
        cpu_addr_i = 32'h0000_0440;
        @(negedge clk_i);
        chk("s4 detect stall", 256'(cpu_stall_o), 256'(1));
        step();
        @(negedge clk_i);
        chk("s4 refill en",   256'(mem_enable_o), 256'(1));
        chk("s4 refill addr", 256'(mem_addr_o),   256'(32'h440));
        rst_i         = 1'b1;
        cpu_MemRead_i = 1'b0;
        step();
        rst_i = 1'b0;
        @(negedge clk_i);
        chkIdleMem("s4 post-rst");
        chk("s4 post-rst addr",  256'(mem_addr_o),  256'(0));
        chk("s4 post-rst stall", 256'(cpu_stall_o), 256'(0));
        chk("s4 post-rst hits",  256'(hit_cnt_o),   256'(0));
        chk("s4 post-rst miss",  256'(miss_cnt_o),  256'(0));
        mem_ack_i = 1'b1;          // stray ack while idle
        step();
        mem_ack_i = 1'b0;
        @(negedge clk_i);
        chkIdleMem("s4 stray ack");
        // 0x240 was valid before reset; it must miss now
        cpu_MemRead_i = 1'b1;
        cpu_addr_i    = 32'h0000_0240;
        @(negedge clk_i);
        chk("s4 reload stall", 256'(cpu_stall_o), 256'(1));
        step();
        mem_ack_i  = 1'b1;
        mem_data_i = line3;
        @(negedge clk_i);
        chk("s4 reload en",   256'(mem_enable_o), 256'(1));
        chk("s4 reload wr",   256'(mem_write_o),  256'(0));
        chk("s4 reload addr", 256'(mem_addr_o),   256'(32'h240));
        step();
        mem_ack_i = 1'b0;
        @(negedge clk_i);
        chk("s4 done en", 256'(mem_enable_o), 256'(0));
        step();
        @(negedge clk_i);
        chk("s4 hit stall", 256'(cpu_stall_o), 256'(0));
        chk("s4 hit data",  256'(cpu_data_o),  256'(32'h3333_3333));

        // ---- S5: read+write together on a hit acts as a store
        step();
        cpu_MemWrite_i = 1'b1;
        cpu_addr_i     = 32'h0000_0248;
        cpu_data_i     = 32'h0000_0005;
        @(negedge clk_i);
        chk("s5 rw stall", 256'(cpu_stall_o), 256'(0));
        chk("s5 rw data",  256'(cpu_data_o),  256'(0));
        step();
        cpu_MemWrite_i = 1'b0;
        cpu_addr_i     = 32'h0000_0048;
        @(negedge clk_i);
        chk("s5 detect stall", 256'(cpu_stall_o), 256'(1));
        step();
        mem_ack_i = 1'b1;
        @(negedge clk_i);
        chk("s5 wb en",    256'(mem_enable_o), 256'(1));
        chk("s5 wb wr",    256'(mem_write_o),  256'(1));
        chk("s5 wb addr",  256'(mem_addr_o),   256'(32'h240));
        chk("s5 wb word2", 256'(mem_data_o[95:64]), 256'(32'h5));
        chk("s5 wb word0", 256'(mem_data_o[31:0]),  256'(32'h3333_3333));
        step();
        mem_data_i = line1;
        @(negedge clk_i);
        chk("s5 refill wr",   256'(mem_write_o), 256'(0));
        chk("s5 refill addr", 256'(mem_addr_o),  256'(32'h40));
        step();
        mem_ack_i = 1'b0;
        @(negedge clk_i);
        chk("s5 done en", 256'(mem_enable_o), 256'(0));
        step();
        @(negedge clk_i);
        chk("s5 hit stall", 256'(cpu_stall_o), 256'(0));
        chk("s5 hit data",  256'(cpu_data_o),  256'(32'hA2A2_A2A2));
        chk("s5 hit count",  256'(hit_cnt_o),  256'(STATS ? 1 : 0));
        chk("s5 miss count", 256'(miss_cnt_o), 256'(STATS ? 2 : 0));
        step();
        cpu_MemRead_i = 1'b0;
        @(negedge clk_i);
        chk("s5 idle stall", 256'(cpu_stall_o), 256'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
